clock_time_counter: RTL
=======================

Name: clock_time_counter

Overview:
Timekeeping core of the digital clock. It consumes the single-cycle 1 Hz enable tick produced by the divider stage and advances an HH:MM:SS count. It provides a button-driven set mode for hours and minutes. It outputs the time in binary and registered packed BCD for the display driver.

Parameters:
HOUR_MAX, 23, largest hour value; hour wraps HOUR_MAX -> 0 (legal 1..23)
MIN_MAX, 59, largest minute value; minute wraps MIN_MAX -> 0
SEC_MAX, 59, largest second value; second wraps SEC_MAX -> 0

Ports:
i_clk  input  1  system clock; sole clock of the block
i_reset  input  1  synchronous, active-high reset
i_tick  input  1  one-cycle-wide 1 Hz enable pulse from the divider
i_btn_mode  input  1  debounced one-cycle pulse; cycles RUN -> SET_HOUR -> SET_MIN -> RUN
i_btn_up  input  1  debounced one-cycle pulse; increments the field being set
o_hour  output  5  binary hour, 0..HOUR_MAX
o_min  output  6  binary minute, 0..MIN_MAX
o_sec  output  6  binary second, 0..SEC_MAX
o_hh_bcd  output  8  packed BCD hour, {tens, ones}
o_mm_bcd  output  8  packed BCD minute
o_ss_bcd  output  8  packed BCD second
o_mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 never driven
o_day_wrap  output  1  one-cycle pulse when the time rolls HOUR_MAX:MIN_MAX:SEC_MAX -> 00:00:00

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high and is sampled only on the rising edge of i_clk.
- Reset values: state RUN; o_mode=0; o_hour, o_min and o_sec = 0; all BCD outputs 8'h00; o_day_wrap=0.
- All outputs are registered. Binary fields update on the edge that samples the qualifying input.
- BCD outputs are converted from the registered binary values and registered again. They lag the binary outputs by exactly one cycle.
- Reset asserted mid-operation, in any state, returns every register to its reset value on that edge. Reset overrides all other inputs.
- RUN state:
  - i_tick=1: sec increments.
  - If sec==SEC_MAX: sec becomes 0 and min increments.
  - If min is also MIN_MAX: min becomes 0 and hour increments.
  - If hour is also HOUR_MAX: hour becomes 0 and o_day_wrap=1 for exactly one cycle.
  - All carries resolve on the same edge; no ripple latency.
- RUN with i_btn_mode=1: go to SET_HOUR and clear sec to 0.
  - i_tick in the same cycle is dropped (mode wins).
  - i_btn_up is ignored in RUN.
- SET_HOUR state:
  - i_btn_up=1: hour = (hour==HOUR_MAX) ? 0 : hour+1.
  - i_btn_mode=1: go to SET_MIN.
- SET_MIN state:
  - i_btn_up=1: min = (min==MIN_MAX) ? 0 : min+1. No carry into hour.
  - i_btn_mode=1: go to RUN.
- In both SET states:
  - i_tick is ignored and sec holds 0.
  - o_day_wrap never asserts.
  - i_btn_mode and i_btn_up asserted together: mode transition wins and the increment is dropped.
- Leaving SET_MIN: sec restarts from 0. The first i_tick after entering RUN makes sec=1.
- o_mode reflects the state register. It changes on the same edge as the transition.
- Input pulses wider than one cycle are not legal. Each cycle a pulse is high counts as one event (no edge detection inside the block).
- BCD conversion covers 0..59 only: tens = value/10, ones = value%10.

Test Plan:
- Reset then 61 i_tick pulses spaced 4 cycles apart -> o_sec=1, o_min=1, o_hour=0; o_ss_bcd=8'h01 one cycle after o_sec updates.
- Set to 23:59:58 via buttons, then 2 ticks -> after the 2nd tick o_hour=0, o_min=0, o_sec=0, o_day_wrap high for exactly 1 cycle, o_hh_bcd=8'h00.
- RUN with o_sec=30; pulse i_tick and i_btn_mode in the same cycle -> o_mode=1, o_sec=0, minute and hour unchanged.
- SET_HOUR with hour=23, pulse i_btn_up -> hour=0. Then mode to SET_MIN with min=59, pulse up -> min=0 and hour stays 0. Ticks during SET leave o_sec=0.
- SET_MIN, assert i_btn_mode and i_btn_up together with min=10 -> o_mode=0, min stays 10. The next tick gives o_sec=1.
- Running at 12:34:56, assert i_reset for 1 cycle together with i_tick -> next cycle all binary outputs 0, o_mode=0. BCD outputs read 8'h00 and o_day_wrap=0.

Source files
------------

// File: rtl/clock_time_counter.sv
// HH:MM:SS timekeeping core with button-driven hour/minute set mode.
// Binary time is registered; packed BCD copies follow one cycle later.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_RUN      | time advances on i_tick, buttons other than mode ignored
// S_SET_HOUR | i_btn_up steps hour, seconds held at 0
// S_SET_MIN  | i_btn_up steps minute (no carry), seconds held at 0
module clock_time_counter #(
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59,
   parameter int SEC_MAX  = 59
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   output logic [4:0] o_hour,
   output logic [5:0] o_min,
   output logic [5:0] o_sec,
   output logic [7:0] o_hh_bcd,
   output logic [7:0] o_mm_bcd,
   output logic [7:0] o_ss_bcd,
   output logic [1:0] o_mode,
   output logic       o_day_wrap
);

   localparam logic [4:0] LP_HOUR_MAX = 5'(HOUR_MAX);
   localparam logic [5:0] LP_MIN_MAX  = 6'(MIN_MAX);
   localparam logic [5:0] LP_SEC_MAX  = 6'(SEC_MAX);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_SET_HOUR = 2'd1,
      S_SET_MIN  = 2'd2
   } state_t;

   state_t     r_state;
   logic [4:0] r_hour;
   logic [5:0] r_min;
   logic [5:0] r_sec;
   logic [7:0] r_hh_bcd;
   logic [7:0] r_mm_bcd;
   logic [7:0] r_ss_bcd;
   logic       r_day_wrap;

   logic w_sec_wrap;
   logic w_min_wrap;
   logic w_hour_wrap;

   assign w_sec_wrap  = (r_sec  == LP_SEC_MAX);
   assign w_min_wrap  = (r_min  == LP_MIN_MAX);
   assign w_hour_wrap = (r_hour == LP_HOUR_MAX);

   // Valid for 0..59 only, which covers every field.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_RUN;
         r_hour     <= '0;
         r_min      <= '0;
         r_sec      <= '0;
         r_hh_bcd   <= '0;
         r_mm_bcd   <= '0;
         r_ss_bcd   <= '0;
         r_day_wrap <= 1'b0;
      end else begin
         r_day_wrap <= 1'b0;
         r_hh_bcd   <= to_bcd({1'b0, r_hour});
         r_mm_bcd   <= to_bcd(r_min);
         r_ss_bcd   <= to_bcd(r_sec);

         case (r_state)
            S_RUN: begin
               // Mode press wins over a coincident tick.
               if (i_btn_mode) begin
                  r_state <= S_SET_HOUR;
                  r_sec   <= '0;
               end else if (i_tick) begin
                  if (w_sec_wrap) begin
                     r_sec <= '0;
                     if (w_min_wrap) begin
                        r_min <= '0;
                        if (w_hour_wrap) begin
                           r_hour     <= '0;
                           r_day_wrap <= 1'b1;
                        end else begin
                           r_hour <= r_hour + 5'd1;
                        end
                     end else begin
                        r_min <= r_min + 6'd1;
                     end
                  end else begin
                     r_sec <= r_sec + 6'd1;
                  end
               end
            end

            S_SET_HOUR: begin
               r_sec <= '0;
               if (i_btn_mode) begin
                  r_state <= S_SET_MIN;
               end else if (i_btn_up) begin
                  r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
               end
            end

            S_SET_MIN: begin
               r_sec <= '0;
               if (i_btn_mode) begin
                  r_state <= S_RUN;
               end else if (i_btn_up) begin
                  r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
               end
            end

            default: begin
               r_state <= S_RUN;
               r_sec   <= '0;
            end
         endcase
      end
   end

   assign o_hour     = r_hour;
   assign o_min      = r_min;
   assign o_sec      = r_sec;
   assign o_hh_bcd   = r_hh_bcd;
   assign o_mm_bcd   = r_mm_bcd;
   assign o_ss_bcd   = r_ss_bcd;
   assign o_mode     = r_state;
   assign o_day_wrap = r_day_wrap;

endmodule
